// File: rtl/key_pkg.sv
// Shared constants and helpers for the pushbutton conditioning block.
package key_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam logic        RELEASED_RAW_ACTIVE_LOW = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  // Raw pin level of an idle key for the given input polarity.
  function automatic logic released_level(input bit active_low);
    return active_low ? RELEASED_RAW_ACTIVE_LOW : ~RELEASED_RAW_ACTIVE_LOW;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: two-flop synchroniser, stability counter, debounced level and
// registered press/release pulses.
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW_IN   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_raw,
  output logic o_state,
  output logic o_press,
  output logic o_release,
  output logic o_press_c
);

  localparam int unsigned            CNT_WIDTH = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic                   RELEASED  = released_level(ACTIVE_LOW_IN);
  localparam logic                   POL       = ACTIVE_LOW_IN;

  logic                 r_sync0;
  logic                 r_sync1;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_state;
  logic                 r_press;
  logic                 r_release;

  logic                 w_s;
  logic                 w_accept;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_state_next;

  assign w_s      = r_sync1 ^ POL;
  assign w_accept = (w_s != r_state) && (r_cnt == CNT_MAX);

  // Any cycle where the input agrees with the accepted level restarts the count.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_state_next = r_state;
    if (w_s == r_state) begin
      w_cnt_next = '0;
    end else if (r_cnt == CNT_MAX) begin
      w_state_next = w_s;
      w_cnt_next   = '0;
    end else begin
      w_cnt_next = r_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync0   <= RELEASED;
      r_sync1   <= RELEASED;
      r_cnt     <= '0;
      r_state   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync0   <= i_key_raw;
      r_sync1   <= r_sync0;
      r_cnt     <= w_cnt_next;
      r_state   <= w_state_next;
      r_press   <= w_accept & w_s;
      r_release <= w_accept & ~w_s;
    end
  end

  assign o_state   = r_state;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_press_c = w_accept & w_s;

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS active-low pushbuttons for the Key PIO and keeps a
// sticky per-key press capture that software clears bit by bit.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW_IN   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_KEYS-1:0] clear_edges,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] edge_capture,
  output logic                any_capture
);

  logic [NUM_KEYS-1:0] w_press_c;
  logic [NUM_KEYS-1:0] w_edge_next;
  logic [NUM_KEYS-1:0] r_edge_capture;
  logic                r_any_capture;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW_IN   (ACTIVE_LOW_IN)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_key_raw (key_raw[g]),
      .o_state   (key_state[g]),
      .o_press   (key_press[g]),
      .o_release (key_release[g]),
      .o_press_c (w_press_c[g])
    );
  end

  // A press arriving in the same cycle as a clear keeps the flag set.
  always_comb begin
    w_edge_next = (r_edge_capture & ~clear_edges) | w_press_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge_capture <= '0;
      r_any_capture  <= 1'b0;
    end else begin
      r_edge_capture <= w_edge_next;
      r_any_capture  <= |w_edge_next;
    end
  end

  assign edge_capture = r_edge_capture;
  assign any_capture  = r_any_capture;

endmodule
